// File: rtl/pe_array_sched_if.sv
// pe_array_sched_if: command, PE-array control and buffer-feed signals of the systolic sequencer
interface pe_array_sched_if #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int KW   = 8
);
  localparam int RW = ROWS > 1 ? $clog2(ROWS) : 1;
  localparam int CW = $clog2(ROWS + COLS);
  logic          start;
  logic          mode;
  logic          acc_mode;
  logic [KW-1:0] k_len;
  logic          busy;
  logic          done;
  logic          err;
  logic          pe_en;
  logic          pe_load;
  logic          pe_data_flow;
  logic          pe_acc_en;
  logic          pe_valid;
  logic [KW-1:0] feed_t;
  logic [ROWS-1:0] a_row_vld;
  logic [COLS-1:0] b_col_vld;
  logic          w_rd_en;
  logic [RW-1:0] w_rd_row;
  logic          psum_rd_en;
  logic          cap_en;
  logic [CW-1:0] cap_idx;
  modport slave (
    input  start, mode, acc_mode, k_len, pe_valid,
    output busy, done, err, pe_en, pe_load, pe_data_flow, pe_acc_en,
           feed_t, a_row_vld, b_col_vld, w_rd_en, w_rd_row, psum_rd_en, cap_en, cap_idx
  );
  modport master (
    output start, mode, acc_mode, k_len, pe_valid,
    input  busy, done, err, pe_en, pe_load, pe_data_flow, pe_acc_en,
           feed_t, a_row_vld, b_col_vld, w_rd_en, w_rd_row, psum_rd_en, cap_en, cap_idx
  );
endinterface

// File: rtl/pe_array_sched.sv
// pe_array_sched: per-tile OS/WS sequencer driving PE_Array controls, skewed feed masks and output capture
module pe_array_sched #(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int KW       = 8,
  parameter int WAIT_MAX = 64
) (
  input logic clk,
  input logic rst_n,
  pe_array_sched_if.slave io
);
  localparam int RW = ROWS > 1 ? $clog2(ROWS) : 1;
  localparam int CW = $clog2(ROWS + COLS);
  localparam int WW = $clog2(WAIT_MAX + 1);
  localparam logic [KW-1:0] R_K   = KW'(ROWS);
  localparam logic [KW-1:0] RC_K  = KW'(ROWS + COLS);
  localparam logic [CW-1:0] N_OS  = CW'(ROWS);
  localparam logic [CW-1:0] N_WS  = CW'(ROWS + COLS - 1);
  localparam logic [WW-1:0] W_END = WW'(WAIT_MAX - 1);
  localparam logic [RW-1:0] R_TOP = RW'(ROWS - 1);
  typedef enum logic [2:0] {IDLE, LOAD, STREAM, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic mode_q, mode_d, acc_q, acc_d, err_q, err_d;
  logic [KW-1:0] k_q, k_d, feed_q, feed_d, lim;
  logic [RW-1:0] ld_q, ld_d;
  logic [CW-1:0] beats_q, beats_d, pop_q, pop_d, n_beats;
  logic [WW-1:0] wait_q, wait_d;
  logic bad, last, cap, pop;
  // zero length, or a stream length that would not fit the feed counter
  assign bad = io.k_len == '0 || ({1'b0, io.k_len} + {1'b0, RC_K}) > (KW+1)'({KW{1'b1}});
  assign lim = mode_q ? k_q + R_K : k_q + RC_K;
  assign last = feed_q == lim - KW'(1);
  assign n_beats = mode_q ? N_WS : N_OS;
  assign cap = io.pe_valid && beats_q < n_beats && (state_q == DRAIN || (state_q == STREAM && last));
  assign pop = mode_q && acc_q && pop_q < N_WS && (state_q == DRAIN || (state_q == STREAM && feed_q >= R_K));
  always_comb begin
    state_d = state_q;
    mode_d = mode_q;
    acc_d = acc_q;
    k_d = k_q;
    err_d = err_q;
    feed_d = feed_q;
    ld_d = ld_q;
    wait_d = wait_q;
    beats_d = beats_q + CW'(cap);
    pop_d = pop_q + CW'(pop);
    case (state_q)
      IDLE: if (io.start) begin
        mode_d = io.mode;
        acc_d = io.acc_mode;
        k_d = io.k_len;
        err_d = bad;
        feed_d = '0;
        ld_d = '0;
        wait_d = '0;
        beats_d = '0;
        pop_d = '0;
        state_d = bad ? DONE : io.mode ? LOAD : STREAM;
      end
      LOAD: begin
        ld_d = ld_q + RW'(1);
        state_d = ld_q == R_TOP ? STREAM : LOAD;
      end
      STREAM: begin
        feed_d = last ? '0 : feed_q + KW'(1);
        state_d = last ? DRAIN : STREAM;
      end
      DRAIN: begin
        wait_d = wait_q + WW'(1);
        state_d = (beats_d == n_beats || wait_q == W_END) ? DONE : DRAIN;
        err_d = beats_d != n_beats && wait_q == W_END;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q <= 1'b0;
      acc_q <= 1'b0;
      err_q <= 1'b0;
      k_q <= '0;
      feed_q <= '0;
      ld_q <= '0;
      wait_q <= '0;
      beats_q <= '0;
      pop_q <= '0;
    end else begin
      state_q <= state_d;
      mode_q <= mode_d;
      acc_q <= acc_d;
      err_q <= err_d;
      k_q <= k_d;
      feed_q <= feed_d;
      ld_q <= ld_d;
      wait_q <= wait_d;
      beats_q <= beats_d;
      pop_q <= pop_d;
    end
  end
  assign io.busy = state_q == LOAD || state_q == STREAM || state_q == DRAIN;
  assign io.done = state_q == DONE;
  assign io.err = state_q == DONE && err_q;
  assign io.pe_en = state_q == STREAM;
  assign io.pe_load = state_q == LOAD;
  assign io.w_rd_en = state_q == LOAD;
  assign io.w_rd_row = state_q == LOAD ? R_TOP - ld_q : '0;
  assign io.pe_data_flow = mode_q;
  assign io.pe_acc_en = acc_q && mode_q && (state_q == STREAM || state_q == DRAIN);
  assign io.feed_t = feed_q;
  assign io.psum_rd_en = pop;
  assign io.cap_en = cap;
  assign io.cap_idx = beats_q;
  for (genvar r = 0; r < ROWS; r++) begin : g_a
    assign io.a_row_vld[r] = state_q == STREAM && feed_q >= KW'(r) && feed_q - KW'(r) < k_q;
  end
  for (genvar c = 0; c < COLS; c++) begin : g_b
    assign io.b_col_vld[c] = state_q == STREAM && !mode_q && feed_q >= KW'(c) && feed_q - KW'(c) < k_q;
  end
endmodule

// File: tb/tb_pe_array_sched.sv
// tb_pe_array_sched: directed OS/WS/boundary/timeout/reset sequences with hand-computed expectations
module tb_pe_array_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  pe_array_sched_if io();
  pe_array_sched dut (.clk(clk), .rst_n(rst_n), .io(io.slave));
  int checks = 0, failures = 0;
  int en_cnt, load_cnt, acc_cnt, psum_cnt, psum_t0, psum_c0, psum_c1;
  int a3_lo, a3_hi, b0_lo, b0_hi, b_any, wrows, caps, cap_n;
  int done_cyc, done_err, drain_n, acc_at_done, busy0, df_stream;
  bit stream_seen, aborted;
  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  function automatic int outs();
    return int'({io.busy, io.done, io.err, io.pe_en, io.pe_load, io.pe_data_flow, io.pe_acc_en,
                 io.feed_t, io.a_row_vld, io.b_col_vld, io.w_rd_en, io.w_rd_row,
                 io.psum_rd_en, io.cap_en, io.cap_idx});
  endfunction
  task automatic run(input bit m, input bit acc, input int k, input int nvld, input int poke_t, input int abort_t);
    int v = 0;
    bit poked = 0;
    en_cnt = 0; load_cnt = 0; acc_cnt = 0; psum_cnt = 0; psum_t0 = -1; psum_c0 = -1; psum_c1 = -1;
    a3_lo = -1; a3_hi = -1; b0_lo = -1; b0_hi = -1; b_any = 0; wrows = 0; caps = 0; cap_n = 0;
    done_cyc = -1; done_err = -1; drain_n = 0; acc_at_done = -1; busy0 = -1; df_stream = -1;
    stream_seen = 0; aborted = 0;
    @(negedge clk);
    io.start = 1'b1; io.mode = m; io.acc_mode = acc; io.k_len = k[7:0]; io.pe_valid = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      io.start = 1'b0;
      io.k_len = k[7:0];
      if (cyc == 0) busy0 = io.busy;
      if (io.done) begin
        done_cyc = cyc; done_err = io.err; acc_at_done = io.pe_acc_en;
        break;
      end
      if (io.pe_load) begin load_cnt++; wrows = wrows * 10 + int'(io.w_rd_row); end
      if (io.pe_acc_en) acc_cnt++;
      if (io.psum_rd_en) begin
        if (psum_cnt == 0) begin psum_c0 = cyc; psum_t0 = io.pe_en ? int'(io.feed_t) : -1; end
        psum_c1 = cyc;
        psum_cnt++;
      end
      if (io.pe_en) begin
        en_cnt++;
        stream_seen = 1;
        df_stream = io.pe_data_flow;
        if (io.a_row_vld[3]) begin if (a3_lo < 0) a3_lo = io.feed_t; a3_hi = io.feed_t; end
        if (io.b_col_vld[0]) begin if (b0_lo < 0) b0_lo = io.feed_t; b0_hi = io.feed_t; end
        if (io.b_col_vld != '0) b_any++;
        if (int'(io.feed_t) == abort_t) begin rst_n = 1'b0; aborted = 1; break; end
        if (int'(io.feed_t) == poke_t && !poked) begin io.start = 1'b1; io.k_len = 8'd1; poked = 1; end
      end
      if (io.busy && !io.pe_en && !io.pe_load && stream_seen) begin
        drain_n++;
        io.pe_valid = v < nvld;
        v++;
      end else io.pe_valid = 1'b0;
      #1;
      if (io.cap_en) begin caps = caps * 10 + int'(io.cap_idx); cap_n++; end
    end
    io.pe_valid = 1'b0;
  endtask
  initial begin
    io.start = 1'b0; io.mode = 1'b0; io.acc_mode = 1'b0; io.k_len = '0; io.pe_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outs", outs(), 0);
    rst_n = 1'b1;
    // OS k=8: L=16, rows skewed by r, four drained rows
    run(0, 0, 8, 4, -1, -1);
    chk("os_busy_after_start", busy0, 1);
    chk("os_en_cycles", en_cnt, 16);
    chk("os_load_cycles", load_cnt, 0);
    chk("os_a3_first", a3_lo, 3);
    chk("os_a3_last", a3_hi, 10);
    chk("os_b0_first", b0_lo, 0);
    chk("os_b0_last", b0_hi, 7);
    chk("os_data_flow", df_stream, 0);
    chk("os_cap_seq", caps, 123);
    chk("os_cap_n", cap_n, 4);
    chk("os_done_cyc", done_cyc, 20);
    chk("os_err", done_err, 0);
    chk("os_psum", psum_cnt, 0);
    // WS k=4 without accumulation
    run(1, 0, 4, 7, -1, -1);
    chk("ws_load_cycles", load_cnt, 4);
    chk("ws_w_rows", wrows, 3210);
    chk("ws_en_cycles", en_cnt, 8);
    chk("ws_a3_first", a3_lo, 3);
    chk("ws_a3_last", a3_hi, 6);
    chk("ws_b_any", b_any, 0);
    chk("ws_data_flow", df_stream, 1);
    chk("ws_psum", psum_cnt, 0);
    chk("ws_acc", acc_cnt, 0);
    chk("ws_cap_seq", caps, 123456);
    chk("ws_done_cyc", done_cyc, 19);
    chk("ws_err", done_err, 0);
    // WS k=4 with accumulation: pops start at feed_t=4 and spill 3 cycles into DRAIN
    run(1, 1, 4, 7, -1, -1);
    chk("wsa_acc_cycles", acc_cnt, 15);
    chk("wsa_acc_done", acc_at_done, 0);
    chk("wsa_psum_cnt", psum_cnt, 7);
    chk("wsa_psum_t0", psum_t0, 4);
    chk("wsa_psum_c0", psum_c0, 8);
    chk("wsa_psum_span", psum_c1 - psum_c0, 6);
    chk("wsa_done_cyc", done_cyc, 19);
    chk("wsa_err", done_err, 0);
    // k_len = 0 and an overflowing k_len are both rejected immediately
    run(0, 0, 0, 0, -1, -1);
    chk("k0_done_cyc", done_cyc, 0);
    chk("k0_err", done_err, 1);
    chk("k0_en", en_cnt, 0);
    run(1, 0, 255, 0, -1, -1);
    chk("kovf_done_cyc", done_cyc, 0);
    chk("kovf_err", done_err, 1);
    chk("kovf_load", load_cnt, 0);
    // start during STREAM is ignored
    run(0, 0, 8, 4, 5, -1);
    chk("poke_en_cycles", en_cnt, 16);
    chk("poke_cap_seq", caps, 123);
    chk("poke_done_cyc", done_cyc, 20);
    chk("poke_err", done_err, 0);
    // timeout: 64 DRAIN cycles then DONE with err
    run(0, 0, 2, 0, -1, -1);
    chk("to_en_cycles", en_cnt, 10);
    chk("to_drain_cycles", drain_n, 64);
    chk("to_done_cyc", done_cyc, 74);
    chk("to_err", done_err, 1);
    chk("to_cap_n", cap_n, 0);
    // reset at feed_t=5 aborts without a done pulse
    run(0, 0, 8, 0, -1, 5);
    chk("abort_seen", int'(aborted), 1);
    chk("abort_en_cycles", en_cnt, 6);
    @(negedge clk);
    chk("abort_outs", outs(), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_no_done", int'({io.done, io.busy}), 0);
    run(0, 0, 3, 4, -1, -1);
    chk("post_en_cycles", en_cnt, 11);
    chk("post_cap_seq", caps, 123);
    chk("post_done_cyc", done_cyc, 15);
    chk("post_err", done_err, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
